// File: rtl/fp_mult_pipe.sv
// rtl/fp_mult_pipe.sv - pipelined signed fixed-point multiplier with rounding, saturation and valid/ready
// Three stages: multiply, round/rescale, range check. A stall at the output
// freezes every stage (bubbles included), so nothing is lost or duplicated.
module fp_mult_pipe #(
   parameter int W_in    = 16,
   parameter int W_in_F  = 14,
   parameter int W_out   = 16,
   parameter int W_out_F = 14,
   parameter int SAT_EN  = 1
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [W_in-1:0]    a,
   input  logic [W_in-1:0]    b,
   input  logic [1:0]         rnd_mode,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [W_out-1:0]   PRODUCT,
   output logic               OVERFLOW,
   output logic               UNDERFLOW,
   output logic               ovf_sticky,
   output logic               unf_sticky,
   input  logic               clr_sticky
);

   localparam int PW = 2 * W_in;
   localparam int RW = PW + 1;
   localparam int SH = 2 * W_in_F - W_out_F;
   localparam logic signed [RW-1:0] MAX = RW'((64'sd1 <<< (W_out - 1)) - 64'sd1);
   localparam logic signed [RW-1:0] MIN = RW'(-(64'sd1 <<< (W_out - 1)));

   generate
      if (W_out_F < 0 || W_out_F > 2 * W_in_F) begin : g_bad_format
         $error("fp_mult_pipe: W_out_F must lie in 0..2*W_in_F");
      end
   endgenerate

   logic                  stall;
   logic                  advance;
   logic                  rdy_q;
   logic                  v1;
   logic signed [PW-1:0]  p1;
   logic [1:0]            m1;
   logic                  v2;
   logic signed [RW-1:0]  r_next;
   logic signed [RW-1:0]  r2;
   logic [W_out-1:0]      prod_c;
   logic                  ovf_c;
   logic                  unf_c;

   assign stall    = out_valid && !out_ready;
   assign advance  = !stall;
   assign in_ready = rdy_q && !stall;

   // in_ready comes up one cycle after reset release
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) rdy_q <= 1'b0;
      else        rdy_q <= 1'b1;
   end

   // S1: full-precision product and the rounding mode that travels with it
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         v1 <= 1'b0;
         p1 <= '0;
         m1 <= 2'd0;
      end else if (advance) begin
         v1 <= in_valid && rdy_q;
         p1 <= $signed(a) * $signed(b);
         m1 <= rnd_mode;
      end
   end

   // S2 combinational rounding of the product down to the output fraction
   generate
      if (SH == 0) begin : g_noshift
         always_comb r_next = {p1[PW-1], p1};
      end else begin : g_shift
         localparam logic signed [RW-1:0] HALF = RW'(1) << (SH - 1);
         localparam logic [SH-1:0]        TIE  = HALF[SH-1:0];
         logic signed [RW-1:0] pe;
         logic signed [RW-1:0] fl;
         logic signed [RW-1:0] up;
         logic [SH-1:0]        frac;
         // one extra bit of headroom keeps P + HALF from overflowing
         always_comb begin
            pe   = {p1[PW-1], p1};
            frac = pe[SH-1:0];
            fl   = pe >>> SH;
            up   = (pe + HALF) >>> SH;
            case (m1)
               2'd0:    r_next = fl;
               2'd1:    r_next = up;
               2'd2:    r_next = (frac == TIE && up[0]) ? up - RW'(1) : up;
               default: r_next = (pe[RW-1] && |frac) ? fl + RW'(1) : fl;
            endcase
         end
      end
   endgenerate

   // S2 register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         v2 <= 1'b0;
         r2 <= '0;
      end else if (advance) begin
         v2 <= v1;
         r2 <= r_next;
      end
   end

   // S3 combinational range check, clamp or wrap
   always_comb begin
      ovf_c  = r2 > MAX;
      unf_c  = r2 < MIN;
      prod_c = r2[W_out-1:0];
      if (SAT_EN != 0) begin
         if (ovf_c)      prod_c = MAX[W_out-1:0];
         else if (unf_c) prod_c = MIN[W_out-1:0];
      end
   end

   // S3 output register; a bubble leaves PRODUCT as-is and clears the flags
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid <= 1'b0;
         PRODUCT   <= '0;
         OVERFLOW  <= 1'b0;
         UNDERFLOW <= 1'b0;
      end else if (advance) begin
         out_valid <= v2;
         OVERFLOW  <= v2 && ovf_c;
         UNDERFLOW <= v2 && unf_c;
         if (v2) PRODUCT <= prod_c;
      end
   end

   // sticky flags record only transferred samples; clear wins over set
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ovf_sticky <= 1'b0;
         unf_sticky <= 1'b0;
      end else if (clr_sticky) begin
         ovf_sticky <= 1'b0;
         unf_sticky <= 1'b0;
      end else if (out_valid && out_ready) begin
         ovf_sticky <= ovf_sticky | OVERFLOW;
         unf_sticky <= unf_sticky | UNDERFLOW;
      end
   end

endmodule

// File: doc/fp_mult_pipe.md
Name: fp_mult_pipe

Overview:
Pipelined, parametrised signed fixed-point multiplier. It is the successor to the combinational fixed-point multiplier.
Adds independent input/output Q formats, selectable rounding, selectable saturate/wrap, valid/ready flow control, per-sample and sticky overflow/underflow flags.
Sits in the fixed-point datapath between producer/consumer blocks using valid/ready streaming.

Parameters:
W_in, 16, word length of a and b
W_in_F, 14, fractional bits of a and b
W_out, 16, word length of PRODUCT
W_out_F, 14, fractional bits of PRODUCT; legal range 0..2*W_in_F, otherwise elaboration error
SAT_EN, 1, 1 = clamp on overflow/underflow, 0 = two's-complement wrap

Ports:
clk  in  1  clock, all state on rising edge
rst_n  in  1  asynchronous active-low reset
in_valid  in  1  operand pair valid
in_ready  out  1  block can accept operands this cycle
a  in  W_in  signed operand
b  in  W_in  signed operand
rnd_mode  in  2  rounding mode, captured with the operands: 0 floor/truncate, 1 round-half-up, 2 round-half-even, 3 toward zero
out_valid  out  1  PRODUCT valid
out_ready  in  1  consumer accepts PRODUCT
PRODUCT  out  W_out  signed result
OVERFLOW  out  1  this sample exceeded max representable
UNDERFLOW  out  1  this sample below min representable
ovf_sticky  out  1  set by any accepted output with OVERFLOW; held until cleared
unf_sticky  out  1  same for UNDERFLOW
clr_sticky  in  1  synchronous clear of both sticky flags

Behaviour:
- Reset (async assert, sync release):
  - all stage valid bits, out_valid, PRODUCT, OVERFLOW, UNDERFLOW, ovf_sticky and unf_sticky = 0
  - in_ready = 1 one cycle after release, combinationally derived
- Reset mid-operation discards all in-flight samples; nothing is emitted after release.
- Handshake:
  - input transfer when in_valid && in_ready; output transfer when out_valid && out_ready.
  - stall = out_valid && !out_ready; in_ready = !stall.
  - On stall every stage holds; no data loss or duplication.
  - PRODUCT and flags are stable while out_valid && !out_ready.
- Pipeline, 3 stages; latency 3 cycles from input transfer to out_valid when not stalled; throughput 1/cycle.
  - S1: register P = a*b, full width 2*W_in, 2*W_in_F fractional bits; register rnd_mode.
  - S2: SH = 2*W_in_F - W_out_F; round P right by SH into R, width 2*W_in+1, no intermediate overflow.
    - mode 0: R = floor(P/2^SH).
    - mode 1: R = floor((P + 2^(SH-1))/2^SH).
    - mode 2: as mode 1, except exact ties go to even R.
    - mode 3: truncate magnitude toward zero.
    - SH = 0: R = P in all modes.
  - S3: MAX = 2^(W_out-1)-1, MIN = -2^(W_out-1).
    - R > MAX: OVERFLOW=1; PRODUCT = MAX if SAT_EN, else R[W_out-1:0].
    - R < MIN: UNDERFLOW=1; PRODUCT = MIN if SAT_EN, else R[W_out-1:0].
    - Otherwise PRODUCT = R[W_out-1:0], both flags 0.
  - OVERFLOW and UNDERFLOW are never both 1.
- Sticky flags:
  - Updated only on output transfer.
  - clr_sticky has priority over a simultaneous set: cleared that cycle; a flagged sample transferring the same cycle is not recorded.
- Bubbles (in_valid=0) propagate as invalid stages. Stages are not compacted, except that a stall freezes all stages including bubbles.

Test Plan:
(Defaults W_in=16, W_in_F=14, W_out=16, W_out_F=14, SAT_EN=1; out_ready=1 unless noted.)
1. Latency: a=0x2000, b=0x2000, mode 0 at cycle t -> out_valid at t+3, PRODUCT=0x1000, flags 0. Then 0x4000*0x4000 -> 0x4000.
2. Rounding, a=0x0001, b=0x2000 (+0.5 LSB) -> modes 0/1/2/3 give 0x0000/0x0001/0x0000/0x0000.
   - a=0x0003 (+1.5 LSB) -> 0x0001/0x0002/0x0002/0x0001.
   - a=0xFFFF (-0.5 LSB) -> 0xFFFF/0x0000/0x0000/0x0000.
3. Saturation:
   - 0x7FFF*0x7FFF -> 0x7FFF, OVERFLOW=1.
   - 0x8000*0x7FFF -> 0x8000, UNDERFLOW=1.
   - 0x8000*0x8000 -> 0x7FFF, OVERFLOW=1.
   - With SAT_EN=0, 0x8000*0x8000 -> 0x0000, OVERFLOW=1.
4. Backpressure: stream 8 operand pairs back-to-back, hold out_ready=0 for 5 cycles mid-stream -> in_ready=0 during the stall, PRODUCT held stable, all 8 results delivered in order with no duplicates.
5. Sticky flags:
   - Overflow sample transfers -> ovf_sticky=1 persists across clean samples.
   - clr_sticky in the same cycle as an underflow transfer -> both stickies 0 next cycle.
6. Reset: assert rst_n=0 with 3 samples in flight -> all outputs 0 immediately. After release, no out_valid until new input; a new sample appears 3 cycles after acceptance.
